seq_chunk_adder: RTL and testbench

//  Multi-cycle, parametrised add/subtract unit. Processes a WIDTH-bit operand pair CHUNK bits per clock.

---
 rtl/seq_chunk_adder_pkg.sv | 15 +
 rtl/seq_chunk_adder_chunk_add.sv | 17 +
 rtl/seq_chunk_adder.sv | 101 ++++++++++
 tb/tb_seq_chunk_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// rtl/seq_chunk_adder_pkg.sv - shared FSM encoding and sizing helper for seq_chunk_adder
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk configuration still needs one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// rtl/seq_chunk_adder_chunk_add.sv - combinational CHUNK-bit adder with carry in/out
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] total;

  assign total   = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(ci);
  assign {co, s} = total;

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock with registered carry
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, c_out_q, ovf_q;
  logic [IDX_W-1:0]   idx_q;
  logic               capture, last;
  int                 base;
  logic [CHUNK-1:0]   x, y, s;
  logic               co;

  assign ready   = (state == ST_IDLE) || (state == ST_DONE);
  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign capture = ready && start;
  assign last    = (idx_q == IDX_W'(NCHUNK - 1));
  assign base    = int'(idx_q) * CHUNK;
  assign x       = a_q[base +: CHUNK];
  assign y       = b_q[base +: CHUNK];

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .x  (x),
    .y  (y),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        // Subtract is folded into the operand: a + ~b + 1.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : c_in;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state == ST_RUN) begin
        sum_q[base +: CHUNK] <= s;
        carry_q              <= co;
        idx_q                <= idx_q + IDX_W'(1);
        if (last) begin
          c_out_q <= co;
          ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - randomized and directed checks of seq_chunk_adder in three configurations
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // d0: WIDTH=32 CHUNK=4, d1: WIDTH=8 CHUNK=8, d2: WIDTH=16 CHUNK=1
  logic        start0 = 0, sub0 = 0, cin0 = 0;
  logic [31:0] a0 = 0, b0 = 0;
  logic        rdy0, bsy0, dn0, co0, ov0;
  logic [31:0] sum0;
  logic        start1 = 0, sub1 = 0, cin1 = 0;
  logic [7:0]  a1 = 0, b1 = 0;
  logic        rdy1, bsy1, dn1, co1, ov1;
  logic [7:0]  sum1;
  logic        start2 = 0, sub2 = 0, cin2 = 0;
  logic [15:0] a2 = 0, b2 = 0;
  logic        rdy2, bsy2, dn2, co2, ov2;
  logic [15:0] sum2;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0), .a(a0), .b(b0), .c_in(cin0),
    .ready(rdy0), .busy(bsy0), .done(dn0), .sum(sum0), .c_out(co0), .overflow(ov0));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .ready(rdy1), .busy(bsy1), .done(dn1), .sum(sum1), .c_out(co1), .overflow(ov1));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .sum(sum2), .c_out(co2), .overflow(ov2));

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 16;
  endfunction

  function automatic int nchunk_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 1 : 16;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? dn0 : (d == 1) ? dn1 : dn2;
  endfunction

  function automatic logic [31:0] get_sum(input int d);
    return (d == 0) ? sum0 : (d == 1) ? {24'd0, sum1} : {16'd0, sum2};
  endfunction

  function automatic logic get_co(input int d);
    return (d == 0) ? co0 : (d == 1) ? co1 : co2;
  endfunction

  function automatic logic get_ov(input int d);
    return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic sb,
                       input logic [31:0] a, input logic [31:0] b, input logic ci);
    case (d)
      0: begin start0 = st; sub0 = sb; a0 = a; b0 = b; cin0 = ci; end
      1: begin start1 = st; sub1 = sb; a1 = a[7:0]; b1 = b[7:0]; cin1 = ci; end
      default: begin start2 = st; sub2 = sb; a2 = a[15:0]; b2 = b[15:0]; cin2 = ci; end
    endcase
  endtask

  task automatic set_start(input int d, input logic st);
    case (d)
      0: start0 = st;
      1: start1 = st;
      default: start2 = st;
    endcase
  endtask

  // Reference: integer arithmetic on the operand values; overflow is the signed result leaving range.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sb, output logic [31:0] s, output logic co, output logic ov);
    longint m, ua, ub, sa, sbv, sr, ur;
    m   = longint'(1) << w;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sbv;
    end else begin
      ur = ua + ub + longint'(ci);
      co = (ur >= m);
      sr = sa + sbv + longint'(ci);
    end
    s  = 32'(ur & (m - 1));
    ov = (sr >= m / 2) || (sr < -(m / 2));
  endtask

  // Called at a negedge with the DUT ready; checks latency and result.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input string tag, input bit chk_lat);
    logic [31:0] es;
    logic        eco, eov;
    int          n;
    model(width_of(d), a, b, ci, sb, es, eco, eov);
    drive(d, 1'b1, sb, a, b, ci);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) set_start(d, 1'b0);
      if (get_done(d)) begin n = i; break; end
    end
    if (n == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      if (chk_lat) check({tag, "_latency"}, n, nchunk_of(d) + 1);
      check({tag, "_sum"}, get_sum(d), es);
      check({tag, "_cout"}, {31'd0, get_co(d)}, {31'd0, eco});
      check({tag, "_ovf"}, {31'd0, get_ov(d)}, {31'd0, eov});
    end
  endtask

  initial begin
    int dones, first_at, second_at;
    logic [31:0] es;
    logic eco, eov;

    repeat (2) @(negedge clk);
    check("rst_sum", sum0, 32'd0);
    check("rst_flags", {28'd0, rdy0, bsy0, dn0, co0 | ov0}, 32'b1000);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "t1", 1);
    run_op(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "t2", 1);
    run_op(0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, "t3", 1);
    @(negedge clk);

    // Start held high through RUN and DONE; operands change mid-run.
    drive(0, 1'b1, 1'b0, 32'h12345678, 32'h11111111, 1'b0);
    dones = 0; first_at = 0; second_at = 0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (j == 1) drive(0, 1'b1, 1'b1, 32'h00000010, 32'h00000020, 1'b1);
      if (dn0) begin
        dones++;
        if (dones == 1) begin
          first_at = j;
          check("t4_sum1", sum0, 32'h23456789);
        end else if (dones == 2) begin
          second_at = j;
          model(32, 32'h10, 32'h20, 1'b1, 1'b1, es, eco, eov);
          check("t4_sum2", sum0, es);
          check("t4_cout2", {31'd0, co0}, {31'd0, eco});
          set_start(0, 1'b0);
        end
      end
    end
    check("t4_dones", dones, 2);
    check("t4_first", first_at, 9);
    check("t4_second", second_at, 18);

    // Async reset in the middle of RUN.
    drive(0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) set_start(0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("t5_sum", sum0, 32'd0);
    check("t5_flags", {28'd0, rdy0, bsy0, dn0, co0 | ov0}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (dn0) dones++;
    end
    check("t5_nodone", dones, 0);
    run_op(0, 32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, "t5_after", 1);

    // Boundary patterns on each configuration.
    run_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, "d1_ovf", 1);
    run_op(1, 32'h80, 32'h01, 1'b0, 1'b1, "d1_subovf", 1);
    run_op(2, 32'hFFFF, 32'h0000, 1'b1, 1'b0, "d2_ripple", 1);
    run_op(2, 32'h8000, 32'h8000, 1'b0, 1'b0, "d2_negovf", 1);

    for (int i = 0; i < 2000; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), "rnd32", (i % 97) == 0);
    for (int i = 0; i < 2000; i++)
      run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), "rnd8", (i % 97) == 0);
    for (int i = 0; i < 600; i++)
      run_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), "rnd16", (i % 97) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
